// File: rtl/eth_tx_framer.sv
// TX framing stage: source MAC insertion, zero-padding to the minimum length,
// truncate/abort of oversize frames, and good/abort frame counters.
module eth_tx_framer #(
  parameter int MinFrameBytes = 60,
  parameter int MaxFrameBytes = 1514,
  parameter int CntWidth      = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [47:0]         mac_address_i,
  input  logic                src_insert_en_i,
  input  logic [7:0]          s_tdata_i,
  input  logic                s_tvalid_i,
  output logic                s_tready_o,
  input  logic                s_tlast_i,
  input  logic                s_tuser_i,
  output logic [7:0]          m_tdata_o,
  output logic                m_tvalid_o,
  input  logic                m_tready_i,
  output logic                m_tlast_o,
  output logic                m_tuser_o,
  output logic [CntWidth-1:0] tx_frames_o,
  output logic [CntWidth-1:0] tx_aborts_o
);

  typedef enum logic [1:0] {IDLE, DATA, PAD, DROP} state_e;

  localparam logic [10:0] MinLast = 11'(MinFrameBytes - 1);
  localparam logic [10:0] MaxLast = 11'(MaxFrameBytes - 1);

  state_e              state_q, state_d;
  logic [10:0]         cnt_q, cnt_d;
  logic [47:0]         mac_q, mac_d;
  logic [7:0]          m_tdata_q, m_tdata_d;
  logic                m_tvalid_q, m_tvalid_d;
  logic                m_tlast_q, m_tlast_d;
  logic                m_tuser_q, m_tuser_d;
  logic [CntWidth-1:0] tx_frames_q, tx_frames_d;
  logic [CntWidth-1:0] tx_aborts_q, tx_aborts_d;
  logic                load, s_hs;
  logic [7:0]          mac_byte, in_byte;

  assign load = !m_tvalid_q || m_tready_i;
  assign s_hs = s_tvalid_i && s_tready_o;

  always_comb begin
    case (state_q)
      PAD:     s_tready_o = 1'b0;
      DROP:    s_tready_o = 1'b1;
      default: s_tready_o = load;
    endcase
  end

  // Station address byte for output positions 6..11, MSB first.
  always_comb begin
    case (cnt_q[3:0])
      4'd6:    mac_byte = mac_q[47:40];
      4'd7:    mac_byte = mac_q[39:32];
      4'd8:    mac_byte = mac_q[31:24];
      4'd9:    mac_byte = mac_q[23:16];
      4'd10:   mac_byte = mac_q[15:8];
      default: mac_byte = mac_q[7:0];
    endcase
    in_byte = (src_insert_en_i && cnt_q >= 11'd6 && cnt_q <= 11'd11) ? mac_byte : s_tdata_i;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mac_d       = mac_q;
    m_tdata_d   = m_tdata_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    m_tuser_d   = m_tuser_q;
    tx_frames_d = tx_frames_q;
    tx_aborts_d = tx_aborts_q;
    if (load) m_tvalid_d = 1'b0;
    case (state_q)
      IDLE, DATA: begin
        if (s_hs) begin
          if (cnt_q == 11'd0) mac_d = mac_address_i;
          m_tvalid_d = 1'b1;
          m_tdata_d  = in_byte;
          m_tlast_d  = 1'b0;
          m_tuser_d  = 1'b0;
          cnt_d      = cnt_q + 11'd1;
          state_d    = DATA;
          if (s_tlast_i) begin
            if (s_tuser_i) begin
              m_tlast_d   = 1'b1;
              m_tuser_d   = 1'b1;
              cnt_d       = '0;
              state_d     = IDLE;
              tx_aborts_d = tx_aborts_q + 1'b1;
            end else if (cnt_q >= MinLast) begin
              m_tlast_d   = 1'b1;
              cnt_d       = '0;
              state_d     = IDLE;
              tx_frames_d = tx_frames_q + 1'b1;
            end else begin
              state_d = PAD;
            end
          end else if (cnt_q == MaxLast) begin
            // Oversize: close the frame as an abort and swallow the rest.
            m_tlast_d   = 1'b1;
            m_tuser_d   = 1'b1;
            cnt_d       = '0;
            state_d     = DROP;
            tx_aborts_d = tx_aborts_q + 1'b1;
          end
        end
      end
      PAD: begin
        if (load) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = 8'h00;
          m_tlast_d  = 1'b0;
          m_tuser_d  = 1'b0;
          cnt_d      = cnt_q + 11'd1;
          if (cnt_q == MinLast) begin
            m_tlast_d   = 1'b1;
            cnt_d       = '0;
            state_d     = IDLE;
            tx_frames_d = tx_frames_q + 1'b1;
          end
        end
      end
      DROP: begin
        if (s_hs && s_tlast_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mac_q       <= '0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tuser_q   <= 1'b0;
      tx_frames_q <= '0;
      tx_aborts_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mac_q       <= mac_d;
      m_tdata_q   <= m_tdata_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      m_tuser_q   <= m_tuser_d;
      tx_frames_q <= tx_frames_d;
      tx_aborts_q <= tx_aborts_d;
    end
  end

  assign m_tdata_o   = m_tdata_q;
  assign m_tvalid_o  = m_tvalid_q;
  assign m_tlast_o   = m_tlast_q;
  assign m_tuser_o   = m_tuser_q;
  assign tx_frames_o = tx_frames_q;
  assign tx_aborts_o = tx_aborts_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: beats are captured by a monitor and
// compared against a reference frame builder.
module tb_eth_tx_framer;
  localparam int MIN = 60;
  localparam int MAX = 1514;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [47:0] mac_address_i = '0;
  logic        src_insert_en_i = 1'b0;
  logic [7:0]  s_tdata_i = '0;
  logic        s_tvalid_i = 1'b0;
  logic        s_tready_o;
  logic        s_tlast_i = 1'b0;
  logic        s_tuser_i = 1'b0;
  logic [7:0]  m_tdata_o;
  logic        m_tvalid_o;
  logic        m_tready_i = 1'b1;
  logic        m_tlast_o;
  logic        m_tuser_o;
  logic [31:0] tx_frames_o;
  logic [31:0] tx_aborts_o;

  eth_tx_framer #(.MinFrameBytes(MIN), .MaxFrameBytes(MAX), .CntWidth(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mac_address_i(mac_address_i),
    .src_insert_en_i(src_insert_en_i), .s_tdata_i(s_tdata_i), .s_tvalid_i(s_tvalid_i),
    .s_tready_o(s_tready_o), .s_tlast_i(s_tlast_i), .s_tuser_i(s_tuser_i),
    .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
    .m_tlast_o(m_tlast_o), .m_tuser_o(m_tuser_o),
    .tx_frames_o(tx_frames_o), .tx_aborts_o(tx_aborts_o));

  always #5 clk_i = ~clk_i;

  int         nchk = 0, nerr = 0;
  int         stall_bad = 0, nrdy_cnt = 0;
  bit         rand_rdy = 1'b0;
  bit         stall_prev = 1'b0;
  logic [9:0] prev_beat;
  logic [9:0] got[$];
  logic [9:0] exp_q[$];

  // Beats are {user, last, data}; sampled mid-cycle.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && (m_tvalid_o !== 1'b1 || {m_tuser_o, m_tlast_o, m_tdata_o} !== prev_beat))
        stall_bad++;
      if (m_tvalid_o && m_tready_i) got.push_back({m_tuser_o, m_tlast_o, m_tdata_o});
      stall_prev = m_tvalid_o && !m_tready_i;
      prev_beat  = {m_tuser_o, m_tlast_o, m_tdata_o};
      if (!s_tready_o) nrdy_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rand_rdy) m_tready_i = 1'($urandom_range(0, 1));
    #1;
  endtask

  task automatic send_frame(input int len, input bit user, input logic [7:0] base, input bit partial);
    bit rdy;
    int j;
    for (int i = 0; i < len; i++) begin
      s_tvalid_i = 1'b1;
      s_tdata_i  = base + 8'(i);
      s_tlast_i  = (i == len - 1) && !partial;
      s_tuser_i  = s_tlast_i && user;
      j = 0;
      forever begin
        rdy = s_tready_o;
        tick();
        if (rdy) break;
        j++;
        if (j > 5000) begin
          check("send_timeout", 32'(j), 32'd0);
          s_tvalid_i = 1'b0;
          return;
        end
      end
    end
    s_tvalid_i = 1'b0;
    s_tlast_i  = 1'b0;
    s_tuser_i  = 1'b0;
  endtask

  // Reference frame builder: expected output beats for one input frame.
  task automatic model(input int len, input bit user, input bit ins, input logic [47:0] mac,
                       input logic [7:0] base);
    int n;
    logic [7:0] d;
    bit l, u;
    n = (len > MAX) ? MAX : len;
    for (int i = 0; i < n; i++) begin
      d = base + 8'(i);
      if (ins && i >= 6 && i <= 11) d = mac[8*(11-i) +: 8];
      l = 1'b0;
      u = 1'b0;
      if (len > MAX && i == MAX - 1) begin l = 1'b1; u = 1'b1; end
      else if (i == len - 1) begin
        if (user) begin l = 1'b1; u = 1'b1; end
        else if (len >= MIN) l = 1'b1;
      end
      exp_q.push_back({u, l, d});
    end
    if (!user && len < MIN)
      for (int i = len; i < MIN; i++) exp_q.push_back({1'b0, i == MIN - 1, 8'h00});
  endtask

  task automatic drain(input int n);
    int j = 0;
    while (got.size() < n && j < 5000) begin tick(); j++; end
    repeat (5) tick();
  endtask

  task automatic cmp(input string tag);
    int bad = 0;
    check({tag, "_beats"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      if (got[i] !== exp_q[i]) bad++;
    check({tag, "_data"}, 32'(bad), 32'd0);
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int n0;
    // Reset state
    tick(); tick();
    check("rst_tvalid", 32'(m_tvalid_o), 32'd0);
    check("rst_tdata", 32'(m_tdata_o), 32'd0);
    check("rst_tlast_user", 32'({m_tlast_o, m_tuser_o}), 32'd0);
    check("rst_frames", tx_frames_o, 32'd0);
    check("rst_aborts", tx_aborts_o, 32'd0);
    check("rst_tready", 32'(s_tready_o), 32'd1);
    rst_ni = 1'b1;
    tick();

    // 64-byte frame with source insertion
    mac_address_i   = 48'h0200_00AA_BBCC;
    src_insert_en_i = 1'b1;
    model(64, 1'b0, 1'b1, mac_address_i, 8'h00);
    send_frame(64, 1'b0, 8'h00, 1'b0);
    drain(64);
    check("f64_byte6", 32'(got[6][7:0]), 32'h02);
    check("f64_byte11", 32'(got[11][7:0]), 32'hCC);
    cmp("f64");
    check("f64_frames", tx_frames_o, 32'd1);

    // 20-byte frame, padded to 60
    src_insert_en_i = 1'b0;
    n0 = nrdy_cnt;
    model(20, 1'b0, 1'b0, mac_address_i, 8'h10);
    send_frame(20, 1'b0, 8'h10, 1'b0);
    drain(60);
    check("pad_tready_low", 32'(nrdy_cnt - n0), 32'd40);
    cmp("pad20");
    check("pad20_frames", tx_frames_o, 32'd2);

    // 20-byte aborted frame, no padding
    model(20, 1'b1, 1'b0, mac_address_i, 8'h40);
    send_frame(20, 1'b1, 8'h40, 1'b0);
    drain(20);
    cmp("abort20");
    check("abort20_aborts", tx_aborts_o, 32'd1);
    check("abort20_frames", tx_frames_o, 32'd2);

    // Oversize frame, then a normal frame back to back
    src_insert_en_i = 1'b1;
    model(1600, 1'b0, 1'b1, mac_address_i, 8'h00);
    model(64, 1'b0, 1'b1, mac_address_i, 8'h80);
    send_frame(1600, 1'b0, 8'h00, 1'b0);
    send_frame(64, 1'b0, 8'h80, 1'b0);
    drain(MAX + 64);
    check("big_last_beat", 32'(got[MAX-1][9:8]), 32'h3);
    cmp("big");
    check("big_aborts", tx_aborts_o, 32'd2);
    check("big_frames", tx_frames_o, 32'd3);

    // Two 100-byte frames with random backpressure
    rand_rdy  = 1'b1;
    stall_bad = 0;
    model(100, 1'b0, 1'b1, mac_address_i, 8'h20);
    model(100, 1'b0, 1'b1, mac_address_i, 8'h55);
    send_frame(100, 1'b0, 8'h20, 1'b0);
    send_frame(100, 1'b0, 8'h55, 1'b0);
    drain(200);
    rand_rdy   = 1'b0;
    m_tready_i = 1'b1;
    repeat (3) tick();
    cmp("bp");
    check("bp_stall_stable", 32'(stall_bad), 32'd0);
    check("bp_frames", tx_frames_o, 32'd5);

    // Reset in the middle of a frame
    send_frame(30, 1'b0, 8'h00, 1'b1);
    s_tvalid_i = 1'b1;
    s_tdata_i  = 8'd30;
    rst_ni     = 1'b0;
    tick();
    rst_ni     = 1'b1;
    s_tvalid_i = 1'b0;
    check("mrst_tvalid", 32'(m_tvalid_o), 32'd0);
    check("mrst_frames", tx_frames_o, 32'd0);
    check("mrst_aborts", tx_aborts_o, 32'd0);
    got.delete();
    mac_address_i = 48'h1234_5678_9ABC;
    model(64, 1'b0, 1'b1, mac_address_i, 8'hC0);
    send_frame(64, 1'b0, 8'hC0, 1'b0);
    drain(64);
    cmp("mrst64");
    check("mrst64_frames", tx_frames_o, 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

Transmit-side framing stage for the 1000BASE-T RGMII Ethernet path. It sits between the host AXI-Stream TX port and the MAC AXIS TX input, in the `clk_i` domain. It overwrites the source MAC field with the configured station address and zero-pads short frames to the Ethernet minimum. It also truncates and aborts oversize frames and counts good and aborted frames for the framing register file.

## Interface
Parameters:
- `MinFrameBytes`, default 60: minimum frame length in bytes, excluding FCS; shorter frames are zero-padded.
- `MaxFrameBytes`, default 1514: maximum frame length in bytes, excluding FCS; longer frames are truncated and aborted.
- `CntWidth`, default 32: width of the statistics counters.

Ports:
- `clk_i`  in  1  125 MHz internal clock.
- `rst_ni`  in  1  reset; one clock; reset is synchronous and active-low.
- `mac_address_i`  in  48  station MAC address; bits [47:40] are transmitted first.
- `src_insert_en_i`  in  1  1 = overwrite bytes 6..11 with `mac_address_i`.
- `s_tdata_i`  in  8  host stream data.
- `s_tvalid_i`  in  1  host stream valid.
- `s_tready_o`  out  1  host stream ready.
- `s_tlast_i`  in  1  last byte of the host frame.
- `s_tuser_i`  in  1  abort request; meaningful only on the last byte.
- `m_tdata_o`  out  8  data to the MAC.
- `m_tvalid_o`  out  1  valid to the MAC.
- `m_tready_i`  in  1  ready from the MAC.
- `m_tlast_o`  out  1  last byte to the MAC.
- `m_tuser_o`  out  1  abort to the MAC; asserted only together with `m_tlast_o`.
- `tx_frames_o`  out  CntWidth  count of frames completed with tuser=0; wraps.
- `tx_aborts_o`  out  CntWidth  count of frames completed with tuser=1; wraps.

## Operation
- The output stage is a single register (`m_*`), loaded when `load = !m_tvalid_o || m_tready_i`.
- `cnt` (11 bits) holds the index of the next output byte in the current frame. It is 0 at frame start and returns to 0 when a last byte is loaded.
- `mac_q` latches `mac_address_i` when byte 0 of a frame is accepted. Bytes 6..11 use `mac_q`, so a mid-frame change to `mac_address_i` has no effect on the current frame.
- State machine: IDLE, DATA, PAD, DROP.
- IDLE / DATA (IDLE is DATA with `cnt` == 0):
  - `s_tready_o = load`.
  - On an input handshake, `m_tdata_o` = the input byte, or `mac_q[8*(11-cnt)+:8]` when `src_insert_en_i` is set and 6 ≤ `cnt` ≤ 11.
  - Input tlast with tuser=1: output last=1, user=1, no padding, counts as an abort.
  - Input tlast with tuser=0 and `cnt`+1 ≥ MinFrameBytes: output last=1, user=0.
  - Input tlast with tuser=0 and `cnt`+1 < MinFrameBytes: output last=0, go to PAD.
  - `cnt` == MaxFrameBytes-1 and input tlast=0: output last=1, user=1, counts as an abort, go to DROP.
- PAD:
  - `s_tready_o` = 0.
  - On each `load`, emit 0x00.
  - At `cnt` == MinFrameBytes-1, emit last=1, user=0, then go to IDLE.
- DROP:
  - `s_tready_o` = 1; input bytes are discarded and the output register is not loaded.
  - The input handshake carrying tlast returns the FSM to IDLE.
- Counters: `tx_frames_o` or `tx_aborts_o` increments by 1 in the cycle a last byte is loaded into the output register, according to that byte's user bit. Both wrap modulo 2^CntWidth.
- An `m_tuser_o`=1 frame is the MAC abort; the MAC discards it.

## Timing
- Reset values, applied on the first `clk_i` edge with `rst_ni`=0:
  - `m_tvalid_o`, `m_tdata_o`, `m_tlast_o`, `m_tuser_o` = 0.
  - `tx_frames_o`, `tx_aborts_o` = 0.
  - `cnt` = 0, state = IDLE, `mac_q` = 0.
  - `s_tready_o` = 1, since it is combinational from the reset state.
- A reset during a frame discards the partial frame with no abort marker; the next input byte is treated as byte 0.
- Latency: 1 cycle from input handshake to `m_tvalid_o`.
- Throughput: 1 byte per cycle with `m_tready_i` held at 1, including back-to-back frames with no idle cycle.
- While `m_tvalid_o`=1 and `m_tready_i`=0, all `m_*` outputs stay stable.
- `s_tready_o` is combinational from state, `m_tvalid_o` and `m_tready_i`; there is no path from `s_tvalid_i` to `s_tready_o`.
- PAD inserts exactly MinFrameBytes-L beats for an input length L < MinFrameBytes, one per `load` cycle.
- Simultaneous events:
  - Input tlast at `cnt` == MaxFrameBytes-1 is a legal maximum-length frame: last=1, user = input tuser, no DROP.
  - Input tlast at `cnt` == MinFrameBytes-1 produces no padding.
  - A 1-byte frame gets padding on bytes 1..59.
  - Source insertion applies only to bytes actually received. Padding bytes in the 6..11 range are 0x00, not MAC bytes.

## Test plan
- MAC 02:00:00:AA:BB:CC, insert enabled, 64-byte frame of incrementing data -> 64 beats. Bytes 6..11 are 02 00 00 AA BB CC, all other bytes unchanged. `m_tlast_o` on byte 63 with user=0. `tx_frames_o`=1.
- 20-byte frame with tuser=0 -> 60 beats. Bytes 20..59 are 0x00 and tlast is on byte 59. `s_tready_o` is low for 40 cycles with `m_tready_i`=1.
- 20-byte frame with tuser=1 on the last byte -> 20 beats, last beat has user=1. `tx_aborts_o`=1, `tx_frames_o` unchanged, no padding.
- 1600-byte frame followed by a 64-byte frame -> first output is 1514 beats with last=1, user=1 on beat 1513. The remaining 86 input bytes are consumed with no output. The 64-byte frame then passes intact.
- Two 100-byte frames with `m_tready_i` toggling pseudo-randomly at 50% -> output byte sequence identical to the `m_tready_i`=1 run. No beat changes while stalled. `tx_frames_o`=2.
- `rst_ni` low for 1 cycle at input byte 30 of a frame -> the following cycle has `m_tvalid_o`=0 and both counters 0. A fresh 64-byte frame then has correct insertion at bytes 6..11.
